legv8_exe_stage: RTL and testbench
==================================

Name: legv8_exe_stage

Overview:
- Execute stage of the 5-stage pipelined LEGv8 CPU.
- Takes ID/EX-latched operands and control, generates ALU control from ALUOp and the 11-bit opcode, performs the ALU operation and the branch-target add, and latches the results into the EX/MEM pipeline register.
- Also contains the PC-select mux that chooses between PC+4 and the latched branch target using the latched Branch and Zero bits.

Parameters:
- WIDTH, 64, datapath width for operands, results, PC and branch target.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- alu_op  in  2  ALUOp from ID/EX
- opcode  in  11  instruction bits [31:21] from ID/EX
- rd1  in  WIDTH  register read data 1 (ALU A)
- rd2  in  WIDTH  register read data 2 (ALU B or store data)
- sign_ext  in  WIDTH  sign-extended immediate
- pc_ex  in  WIDTH  PC of the instruction in EX
- alu_src  in  1  1 selects sign_ext as ALU B, 0 selects rd2
- reg_write, mem_to_reg, branch, mem_read, mem_write  in  1 each  control bits passed through
- write_reg  in  5  destination register (Rd/Rt)
- pc_plus4  in  WIDTH  PC+4 from IF
- reg_write_m, mem_to_reg_m, branch_m, mem_read_m, mem_write_m  out  1 each  latched control
- branch_target_m  out  WIDTH  latched branch target
- zero_m  out  1  latched ALU zero flag
- alu_result_m  out  WIDTH  latched ALU result
- rd2_m  out  WIDTH  latched store data
- write_reg_m  out  5  latched destination register
- pc_src  out  1  branch_m AND zero_m (combinational)
- pc_next  out  WIDTH  pc_src ? branch_target_m : pc_plus4 (combinational)

Behaviour:
- ALU control (combinational):
  - alu_op=00 → ADD (0010)
  - alu_op=01 → PASS_B (0111)
  - alu_op=10 → decode opcode:
    - 10001011000 ADD → 0010
    - 11001011000 SUB → 0110
    - 10001010000 AND → 0000
    - 10101010000 ORR → 0001
    - any other opcode → ADD
  - alu_op=11 → ADD
- ALU operations:
  - B = alu_src ? sign_ext : rd2
  - 0000 A&B; 0001 A|B; 0010 A+B; 0110 A−B; 0111 B; 1100 ~(A|B); any other code → 0
- Arithmetic: modulo 2^WIDTH, no carry or overflow outputs.
- zero = (ALU result == 0).
- Branch target = pc_ex + (sign_ext << 2), truncated to WIDTH.
- EX/MEM register: on each rising clk, latch all control bits, branch target, zero, ALU result, rd2 and write_reg.
  - No enable, stall or flush; one-cycle latency from inputs to *_m outputs.
- Reset: rst_n low asynchronously clears every *_m output to 0.
  - Consequently pc_src=0 and pc_next=pc_plus4 while in reset.
  - Release of rst_n is synchronous to the next rising edge.
- PC mux is purely combinational on registered values, so a taken branch redirects the PC one cycle after the branch leaves EX.
- Control bits are passed through unmodified; mem_read and mem_write are never gated.
- Reset asserted mid-operation discards the in-flight EX/MEM contents. There is no held state beyond the register.

Test Plan:
- Reset: rst_n=0 with nonzero inputs, pc_plus4=0x10 → all *_m=0, pc_src=0, pc_next=0x10. These hold across clock edges until rst_n=1.
- R-type: alu_op=10 with rd1=7, rd2=5, alu_src=0.
  - opcode ADD → alu_result_m=12 after one edge.
  - SUB → 2.
  - AND → 5.
  - ORR → 7.
  - Undefined opcode → 12.
- Load/store: alu_op=00, alu_src=1, rd1=0x100, sign_ext=8, rd2=0xAB, mem_write=1 → alu_result_m=0x108, rd2_m=0xAB, mem_write_m=1, zero_m=0.
- CBZ taken: alu_op=01, rd2=0, branch=1, pc_ex=0x40, sign_ext=3 → branch_target_m=0x4C, zero_m=1, pc_src=1, pc_next=0x4C.
- CBZ not taken: rd2=9 → zero_m=0, pc_src=0, pc_next=pc_plus4.
- Edge cases:
  - SUB with rd1=rd2=0xFFFF_FFFF_FFFF_FFFF → result 0, zero_m=1.
  - ADD 0xFFFF_FFFF_FFFF_FFFF+1 → 0 (wrap).
  - Negative offset sign_ext=−2, pc_ex=0x20 → target 0x18.

Source files
------------

// File: rtl/legv8_exe_stage.sv
// LEGv8 execute stage: ALU control decode, ALU, branch-target adder,
// EX/MEM pipeline register and the PC-select mux that follows it.
module legv8_exe_stage #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       alu_op,
   input  logic [10:0]      opcode,
   input  logic [WIDTH-1:0] rd1,
   input  logic [WIDTH-1:0] rd2,
   input  logic [WIDTH-1:0] sign_ext,
   input  logic [WIDTH-1:0] pc_ex,
   input  logic             alu_src,
   input  logic             reg_write,
   input  logic             mem_to_reg,
   input  logic             branch,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic [4:0]       write_reg,
   input  logic [WIDTH-1:0] pc_plus4,
   output logic             reg_write_m,
   output logic             mem_to_reg_m,
   output logic             branch_m,
   output logic             mem_read_m,
   output logic             mem_write_m,
   output logic [WIDTH-1:0] branch_target_m,
   output logic             zero_m,
   output logic [WIDTH-1:0] alu_result_m,
   output logic [WIDTH-1:0] rd2_m,
   output logic [4:0]       write_reg_m,
   output logic             pc_src,
   output logic [WIDTH-1:0] pc_next
);

   localparam logic [3:0] ALU_AND    = 4'b0000;
   localparam logic [3:0] ALU_ORR    = 4'b0001;
   localparam logic [3:0] ALU_ADD    = 4'b0010;
   localparam logic [3:0] ALU_SUB    = 4'b0110;
   localparam logic [3:0] ALU_PASS_B = 4'b0111;
   localparam logic [3:0] ALU_NOR    = 4'b1100;

   localparam logic [10:0] OPC_ADD = 11'b10001011000;
   localparam logic [10:0] OPC_SUB = 11'b11001011000;
   localparam logic [10:0] OPC_AND = 11'b10001010000;
   localparam logic [10:0] OPC_ORR = 11'b10101010000;

   logic [3:0]       alu_ctrl;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_result;
   logic             alu_zero;
   logic [WIDTH-1:0] branch_target;

   // ALU control: memory ops add, CBZ passes B, R-type decodes the opcode
   always_comb begin
      alu_ctrl = ALU_ADD;
      case (alu_op)
         2'b00: alu_ctrl = ALU_ADD;
         2'b01: alu_ctrl = ALU_PASS_B;
         2'b10: begin
            case (opcode)
               OPC_ADD: alu_ctrl = ALU_ADD;
               OPC_SUB: alu_ctrl = ALU_SUB;
               OPC_AND: alu_ctrl = ALU_AND;
               OPC_ORR: alu_ctrl = ALU_ORR;
               default: alu_ctrl = ALU_ADD;
            endcase
         end
         default: alu_ctrl = ALU_ADD;
      endcase
   end

   assign alu_b = alu_src ? sign_ext : rd2;

   // ALU datapath; NOR is supported even though the decoder never selects it
   always_comb begin
      alu_result = '0;
      case (alu_ctrl)
         ALU_AND:    alu_result = rd1 & alu_b;
         ALU_ORR:    alu_result = rd1 | alu_b;
         ALU_ADD:    alu_result = rd1 + alu_b;
         ALU_SUB:    alu_result = rd1 - alu_b;
         ALU_PASS_B: alu_result = alu_b;
         ALU_NOR:    alu_result = ~(rd1 | alu_b);
         default:    alu_result = '0;
      endcase
   end

   assign alu_zero      = (alu_result == '0);
   assign branch_target = pc_ex + (sign_ext << 2);

   // EX/MEM pipeline register, cleared asynchronously by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_write_m     <= 1'b0;
         mem_to_reg_m    <= 1'b0;
         branch_m        <= 1'b0;
         mem_read_m      <= 1'b0;
         mem_write_m     <= 1'b0;
         branch_target_m <= '0;
         zero_m          <= 1'b0;
         alu_result_m    <= '0;
         rd2_m           <= '0;
         write_reg_m     <= '0;
      end else begin
         reg_write_m     <= reg_write;
         mem_to_reg_m    <= mem_to_reg;
         branch_m        <= branch;
         mem_read_m      <= mem_read;
         mem_write_m     <= mem_write;
         branch_target_m <= branch_target;
         zero_m          <= alu_zero;
         alu_result_m    <= alu_result;
         rd2_m           <= rd2;
         write_reg_m     <= write_reg;
      end
   end

   // PC select works on the latched branch/zero, so redirect lands one cycle later
   assign pc_src  = branch_m & zero_m;
   assign pc_next = pc_src ? branch_target_m : pc_plus4;

endmodule

// File: tb/tb_legv8_exe_stage.sv
// Self-checking bench for legv8_exe_stage: directed cases plus random
// transactions checked against a behavioural model of the execute stage.
module tb_legv8_exe_stage;

   typedef struct packed {
      logic [1:0]  alu_op;
      logic [10:0] opcode;
      logic [63:0] rd1;
      logic [63:0] rd2;
      logic [63:0] sign_ext;
      logic [63:0] pc_ex;
      logic [63:0] pc_plus4;
      logic        alu_src;
      logic [4:0]  ctrl;      // {reg_write, mem_to_reg, branch, mem_read, mem_write}
      logic [4:0]  write_reg;
   } stim_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  alu_op;
   logic [10:0] opcode;
   logic [63:0] rd1, rd2, sign_ext, pc_ex, pc_plus4;
   logic        alu_src;
   logic        reg_write, mem_to_reg, branch, mem_read, mem_write;
   logic [4:0]  write_reg;
   logic        reg_write_m, mem_to_reg_m, branch_m, mem_read_m, mem_write_m;
   logic [63:0] branch_target_m, alu_result_m, rd2_m, pc_next;
   logic        zero_m, pc_src;
   logic [4:0]  write_reg_m;

   int total = 0;
   int bad   = 0;
   int txn   = 0;

   legv8_exe_stage #(.WIDTH(64)) dut (
      .clk(clk), .rst_n(rst_n), .alu_op(alu_op), .opcode(opcode),
      .rd1(rd1), .rd2(rd2), .sign_ext(sign_ext), .pc_ex(pc_ex),
      .alu_src(alu_src), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
      .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
      .write_reg(write_reg), .pc_plus4(pc_plus4),
      .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m),
      .branch_m(branch_m), .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
      .branch_target_m(branch_target_m), .zero_m(zero_m),
      .alu_result_m(alu_result_m), .rd2_m(rd2_m), .write_reg_m(write_reg_m),
      .pc_src(pc_src), .pc_next(pc_next)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drive(input stim_t st);
      alu_op    = st.alu_op;
      opcode    = st.opcode;
      rd1       = st.rd1;
      rd2       = st.rd2;
      sign_ext  = st.sign_ext;
      pc_ex     = st.pc_ex;
      pc_plus4  = st.pc_plus4;
      alu_src   = st.alu_src;
      {reg_write, mem_to_reg, branch, mem_read, mem_write} = st.ctrl;
      write_reg = st.write_reg;
   endtask

   // Reference model: what the instruction means, computed directly
   function automatic logic [63:0] model_result(input stim_t st);
      logic [63:0] b;
      b = st.alu_src ? st.sign_ext : st.rd2;
      if (st.alu_op == 2'b01) return b;                 // CBZ: test B
      if (st.alu_op == 2'b10) begin
         if (st.opcode == 11'b11001011000) return st.rd1 - b;
         if (st.opcode == 11'b10001010000) return st.rd1 & b;
         if (st.opcode == 11'b10101010000) return st.rd1 | b;
         return st.rd1 + b;                             // ADD and unknown opcodes
      end
      return st.rd1 + b;                                // address calc / default
   endfunction

   function automatic stim_t base_stim();
      stim_t st;
      st = '0;
      st.pc_plus4 = 64'h1000;
      return st;
   endfunction

   // One transaction: drive on the falling edge, check just after the rising edge
   task automatic run_txn(input stim_t st, input string name);
      logic [63:0] res, tgt, nxt;
      logic        z, taken;
      @(negedge clk);
      drive(st);
      @(posedge clk);
      #1;
      res   = model_result(st);
      z     = (res == 64'd0);
      tgt   = st.pc_ex + st.sign_ext * 64'd4;
      taken = st.ctrl[2] && z;
      nxt   = taken ? tgt : st.pc_plus4;
      check({name, ".result"}, alu_result_m, res);
      check({name, ".zero"}, {63'd0, zero_m}, {63'd0, z});
      check({name, ".target"}, branch_target_m, tgt);
      check({name, ".rd2"}, rd2_m, st.rd2);
      check({name, ".wreg"}, {59'd0, write_reg_m}, {59'd0, st.write_reg});
      check({name, ".ctrl"},
            {59'd0, reg_write_m, mem_to_reg_m, branch_m, mem_read_m, mem_write_m},
            {59'd0, st.ctrl});
      check({name, ".pc_src"}, {63'd0, pc_src}, {63'd0, taken});
      check({name, ".pc_next"}, pc_next, nxt);
      txn++;
      $display("txn %0d %s: op=%b opc=%b res=%h zero=%b tgt=%h pc_next=%h",
               txn, name, st.alu_op, st.opcode, alu_result_m, zero_m, branch_target_m, pc_next);
   endtask

   task automatic check_cleared(input string name, input logic [63:0] p4);
      check({name, ".ctrl"},
            {59'd0, reg_write_m, mem_to_reg_m, branch_m, mem_read_m, mem_write_m}, 64'd0);
      check({name, ".target"}, branch_target_m, 64'd0);
      check({name, ".result"}, alu_result_m, 64'd0);
      check({name, ".zero"}, {63'd0, zero_m}, 64'd0);
      check({name, ".rd2"}, rd2_m, 64'd0);
      check({name, ".wreg"}, {59'd0, write_reg_m}, 64'd0);
      check({name, ".pc_src"}, {63'd0, pc_src}, 64'd0);
      check({name, ".pc_next"}, pc_next, p4);
      $display("reset check %s: res=%h pc_next=%h", name, alu_result_m, pc_next);
   endtask

   initial begin
      stim_t st;
      int    sel;

      // Reset with busy inputs: outputs must stay cleared across edges
      rst_n = 1'b0;
      st = '{alu_op: 2'b10, opcode: 11'b10001011000, rd1: 64'h7, rd2: 64'h5,
             sign_ext: 64'h3, pc_ex: 64'h40, pc_plus4: 64'h10, alu_src: 1'b0,
             ctrl: 5'b11111, write_reg: 5'd9};
      drive(st);
      #1;
      check_cleared("reset0", 64'h10);
      repeat (3) @(posedge clk);
      #1;
      check_cleared("reset3", 64'h10);
      @(negedge clk);
      rst_n = 1'b1;

      // R-type with rd1=7, rd2=5
      st = base_stim(); st.alu_op = 2'b10; st.rd1 = 64'd7; st.rd2 = 64'd5;
      st.ctrl = 5'b10000; st.write_reg = 5'd3;
      st.opcode = 11'b10001011000; run_txn(st, "r_add"); check("r_add.lit", alu_result_m, 64'd12);
      st.opcode = 11'b11001011000; run_txn(st, "r_sub"); check("r_sub.lit", alu_result_m, 64'd2);
      st.opcode = 11'b10001010000; run_txn(st, "r_and"); check("r_and.lit", alu_result_m, 64'd5);
      st.opcode = 11'b10101010000; run_txn(st, "r_orr"); check("r_orr.lit", alu_result_m, 64'd7);
      st.opcode = 11'b11111000010; run_txn(st, "r_undef"); check("r_undef.lit", alu_result_m, 64'd12);

      // Store: address = rd1 + imm, store data passes through
      st = base_stim(); st.alu_op = 2'b00; st.alu_src = 1'b1; st.rd1 = 64'h100;
      st.sign_ext = 64'd8; st.rd2 = 64'hAB; st.ctrl = 5'b00001;
      run_txn(st, "store");
      check("store.lit", alu_result_m, 64'h108);
      check("store.memw", {63'd0, mem_write_m}, 64'd1);

      // CBZ taken then not taken
      st = base_stim(); st.alu_op = 2'b01; st.rd2 = 64'd0; st.ctrl = 5'b00100;
      st.pc_ex = 64'h40; st.sign_ext = 64'd3; st.rd1 = 64'h55;
      run_txn(st, "cbz_taken");
      check("cbz_taken.lit", pc_next, 64'h4C);
      st.rd2 = 64'd9;
      run_txn(st, "cbz_not");
      check("cbz_not.lit", pc_next, 64'h1000);

      // Edge cases: all-ones subtract, wrap-around add, negative offset
      st = base_stim(); st.alu_op = 2'b10; st.opcode = 11'b11001011000;
      st.rd1 = '1; st.rd2 = '1; st.ctrl = 5'b00100;
      run_txn(st, "sub_ones");
      check("sub_ones.zero", {63'd0, zero_m}, 64'd1);
      st.opcode = 11'b10001011000; st.rd2 = 64'd1;
      run_txn(st, "add_wrap");
      check("add_wrap.lit", alu_result_m, 64'd0);
      st = base_stim(); st.sign_ext = -64'sd2; st.pc_ex = 64'h20; st.rd1 = 64'd1;
      run_txn(st, "neg_off");
      check("neg_off.lit", branch_target_m, 64'h18);

      // Mid-operation reset discards the in-flight register contents
      st = base_stim(); st.alu_op = 2'b01; st.ctrl = 5'b11111; st.pc_ex = 64'h80;
      st.sign_ext = 64'd4; st.write_reg = 5'd31;
      run_txn(st, "pre_reset");
      #2;
      rst_n = 1'b0;
      #1;
      check_cleared("async_rst", st.pc_plus4);
      @(posedge clk);
      #1;
      check_cleared("held_rst", st.pc_plus4);
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized transactions
      for (int i = 0; i < 300; i++) begin
         st.alu_op    = 2'($urandom_range(0, 3));
         sel          = int'($urandom_range(0, 4));
         case (sel)
            0: st.opcode = 11'b10001011000;
            1: st.opcode = 11'b11001011000;
            2: st.opcode = 11'b10001010000;
            3: st.opcode = 11'b10101010000;
            default: st.opcode = 11'($urandom);
         endcase
         st.rd1       = {$urandom, $urandom};
         st.rd2       = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) st.rd1 = st.rd2;
         st.sign_ext  = ($urandom_range(0, 1) == 0) ? {{52{1'b1}}, 12'($urandom)}
                                                    : {$urandom, $urandom};
         st.pc_ex     = {$urandom, $urandom};
         st.pc_plus4  = {$urandom, $urandom};
         st.alu_src   = 1'($urandom);
         st.ctrl      = 5'($urandom);
         st.write_reg = 5'($urandom);
         run_txn(st, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
